// File: rtl/pic_pkg.sv
// Shared definitions for the parametrised PIC: register map, CTRL/EOI bit
// positions and the acknowledge FSM states.
package pic_pkg;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_VBASE = 2'd1;
  localparam logic [1:0] ADDR_IMR   = 2'd2;
  localparam logic [1:0] ADDR_EOI   = 2'd3;

  localparam logic [1:0] RD_IRR  = 2'd0;
  localparam logic [1:0] RD_ISR  = 2'd1;
  localparam logic [1:0] RD_IMR  = 2'd2;
  localparam logic [1:0] RD_STAT = 2'd3;

  localparam int CTRL_LTIM    = 0;
  localparam int CTRL_ROT     = 1;
  localparam int CTRL_AEOI    = 2;
  localparam int EOI_SPECIFIC = 7;

  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } state_t;

endpackage

// File: rtl/pic_prio_resolver.sv
// Rotating priority encoder: the line after pp wins first, scanning upward
// with wrap-around; returns whether any request exists and its index.
module pic_prio_resolver #(
  parameter int N_IRQ = 8,
  parameter int IDW   = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [IDW-1:0]   pp,
  output logic             valid,
  output logic [IDW-1:0]   idx
);

  localparam logic [IDW-1:0] ONE = IDW'(1);

  logic [IDW-1:0] start;

  assign start = pp + ONE;

  // Scan from lowest rank to highest; the last hit written is the best rank.
  always_comb begin
    logic [IDW-1:0] j;
    j     = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      j = start + i[IDW-1:0];
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/pic_param_ctrl.sv
// Parametrised 8259-style interrupt controller: edge/level capture, masking,
// fully nested rotating priority, two-pulse INTA_ vector handshake, auto-EOI.
module pic_param_ctrl
  import pic_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int IDW   = $clog2(N_IRQ)
) (
  input  logic             CLK,
  input  logic             RST_,
  input  logic             CS_,
  input  logic             WR_,
  input  logic             RD_,
  input  logic [1:0]       A,
  input  logic [N_IRQ-1:0] WDATA,
  output logic [N_IRQ-1:0] RDATA,
  input  logic [N_IRQ-1:0] IR,
  input  logic             INTA_,
  output logic             INT,
  output logic [7:0]       VECTOR,
  output logic             VEC_VALID
);

  localparam logic [IDW-1:0] ONE     = IDW'(1);
  localparam logic [7:0]     VB_MASK = 8'((1 << IDW) - 1);

  logic [N_IRQ-1:0] irr, isr, imr, ir_q;
  logic [2:0]       ctrl;
  logic [7:0]       vbase;
  logic [IDW-1:0]   pp, win;
  logic             spur;
  state_t           state;

  logic             wr, rd, inta;
  logic             req_v, isr_v, req_above;
  logic [IDW-1:0]   req_idx, isr_idx, start, req_rank, isr_rank, eoi_id, rot_id;
  logic             rot_ld;
  logic [N_IRQ-1:0] isr_set, isr_clr, irr_clr, status;

  assign wr     = !CS_ && !WR_;
  assign rd     = !CS_ && !RD_;
  assign inta   = !INTA_;
  assign eoi_id = WDATA[IDW-1:0];

  pic_prio_resolver #(.N_IRQ(N_IRQ), .IDW(IDW)) u_req_res (
    .req   (irr & ~imr),
    .pp    (pp),
    .valid (req_v),
    .idx   (req_idx)
  );

  pic_prio_resolver #(.N_IRQ(N_IRQ), .IDW(IDW)) u_isr_res (
    .req   (isr),
    .pp    (pp),
    .valid (isr_v),
    .idx   (isr_idx)
  );

  // Ranks relative to the pointer; smaller rank means higher priority.
  assign start     = pp + ONE;
  assign req_rank  = req_idx - start;
  assign isr_rank  = isr_idx - start;
  assign req_above = req_v && (!isr_v || (req_rank < isr_rank));

  always_comb begin
    status             = '0;
    status[IDW-1:0]    = pp;
    status[IDW+2:IDW]  = ctrl;
  end

  always_comb begin
    isr_set = '0;
    irr_clr = '0;
    isr_clr = '0;
    rot_ld  = 1'b0;
    rot_id  = pp;
    if (state == IDLE && inta && req_above) begin
      isr_set[req_idx] = 1'b1;
      irr_clr[req_idx] = 1'b1;
    end
    if (wr && A == ADDR_EOI) begin
      if (WDATA[EOI_SPECIFIC]) begin
        if (isr[eoi_id]) begin
          isr_clr[eoi_id] = 1'b1;
          rot_ld          = 1'b1;
          rot_id          = eoi_id;
        end
      end else if (isr_v) begin
        isr_clr[isr_idx] = 1'b1;
        rot_ld           = 1'b1;
        rot_id           = isr_idx;
      end
    end
    if (state == ACK1 && inta && ctrl[CTRL_AEOI] && !spur) begin
      isr_clr[win] = 1'b1;
      rot_ld       = 1'b1;
      rot_id       = win;
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      irr       <= '0;
      isr       <= '0;
      imr       <= '1;
      ir_q      <= '0;
      ctrl      <= '0;
      vbase     <= '0;
      pp        <= '1;
      win       <= '0;
      spur      <= 1'b0;
      state     <= IDLE;
      INT       <= 1'b0;
      VECTOR    <= '0;
      VEC_VALID <= 1'b0;
      RDATA     <= '0;
    end else begin
      ir_q <= IR;
      if (ctrl[CTRL_LTIM]) irr <= IR;
      else                 irr <= (irr & ~irr_clr) | (IR & ~ir_q);
      isr <= (isr | isr_set) & ~isr_clr;
      INT <= req_above;

      if (wr) begin
        case (A)
          ADDR_CTRL:  ctrl  <= WDATA[2:0];
          ADDR_VBASE: vbase <= WDATA[7:0] & ~VB_MASK;
          ADDR_IMR:   imr   <= WDATA;
          default:    ;
        endcase
      end

      if (!ctrl[CTRL_ROT]) pp <= '1;
      else if (rot_ld)     pp <= rot_id;

      if (rd) begin
        case (A)
          RD_IRR:  RDATA <= irr;
          RD_ISR:  RDATA <= isr;
          RD_IMR:  RDATA <= imr;
          default: RDATA <= status;
        endcase
      end

      VEC_VALID <= 1'b0;
      case (state)
        IDLE: if (inta) begin
          win   <= req_above ? req_idx : '1;
          spur  <= !req_above;
          state <= ACK1;
        end
        default: if (inta) begin
          VECTOR    <= vbase | {{(8-IDW){1'b0}}, win};
          VEC_VALID <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
